// File: rtl/vec_pkg.sv
// Shared constants and types for the vector demux router: select codes,
// default vector geometry and the select-code decoder.
package vec_pkg;

   // Destination select codes
   localparam logic [1:0] SEL_CH0 = 2'b00;
   localparam logic [1:0] SEL_CH1 = 2'b01;
   localparam logic [1:0] SEL_CH2 = 2'b10;
   localparam logic [1:0] SEL_INV = 2'b11;

   // Default vector geometry
   localparam int VEC_N = 16;
   localparam int VEC_M = 16;

   typedef logic [VEC_M-1:0][VEC_N-1:0] vec_t;

   // One-hot decode of a select code onto the three channels.
   // The invalid code maps to no channel.
   function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
      logic [2:0] hit;
      hit = 3'b000;
      case (sel)
         SEL_CH0: hit = 3'b001;
         SEL_CH1: hit = 3'b010;
         SEL_CH2: hit = 3'b100;
         default: hit = 3'b000;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/vec_demux3_router_if.sv
// Valid/ready bundle between one vector source and three vector sinks.
// The router takes the slave view; the environment driving it takes master.
interface vec_demux3_router_if #(
   parameter int N = 16,
   parameter int M = 16
);
   logic                   in_valid;
   logic                   in_ready;
   logic [1:0]             in_sel;
   logic [M-1:0][N-1:0]    in_data;
   logic [2:0]             out_valid;
   logic [2:0]             out_ready;
   logic [M-1:0][N-1:0]    out_data0;
   logic [M-1:0][N-1:0]    out_data1;
   logic [M-1:0][N-1:0]    out_data2;

   modport master (
      output in_valid, in_sel, in_data, out_ready,
      input  in_ready, out_valid, out_data0, out_data1, out_data2
   );

   modport slave (
      input  in_valid, in_sel, in_data, out_ready,
      output in_ready, out_valid, out_data0, out_data1, out_data2
   );
endinterface

// File: rtl/vec_demux3_router_slot.sv
// One-entry registered output slot. A load always wins over a drain so a
// slot that is drained and loaded in the same cycle stays full with the new
// vector, giving one vector per cycle per channel.
module vec_out_slot #(
   parameter int N = 16,
   parameter int M = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_load,
   input  logic                i_drain,
   input  logic [M-1:0][N-1:0] i_data,
   output logic                o_full,
   output logic [M-1:0][N-1:0] o_data
);

   logic                r_full;
   logic [M-1:0][N-1:0] r_data;

   // Full bit: EMPTY->FULL on load, FULL->EMPTY on drain without load
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_full <= 1'b0;
      end else if (i_load) begin
         r_full <= 1'b1;
      end else if (i_drain) begin
         r_full <= 1'b0;
      end
   end

   // Payload: captured on load, otherwise held (also after a drain)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data <= '0;
      end else if (i_load) begin
         r_data <= i_data;
      end
   end

   assign o_full = r_full;
   assign o_data = r_data;

endmodule

// File: rtl/vec_demux3_router.sv
// Routes one vector per transfer from a single valid/ready source to one of
// three registered output slots. The invalid select code is accepted
// unconditionally, dropped, and tallied in a saturating counter with a
// sticky flag.
module vec_demux3_router
   import vec_pkg::*;
#(
   parameter int N     = 16,
   parameter int M     = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   vec_demux3_router_if.slave bus,
   input  logic             clr_err,
   output logic [CNT_W-1:0] drop_count,
   output logic             drop_flag
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [2:0]             w_hit;
   logic [2:0]             w_full;
   logic [2:0]             w_load;
   logic [2:0]             w_drain;
   logic                   w_in_ready;
   logic                   w_accept;
   logic                   w_drop;
   logic [M-1:0][N-1:0]    w_slot_data [3];

   logic [CNT_W-1:0]       r_drop_count;
   logic [CNT_W-1:0]       w_drop_count_next;
   logic                   r_drop_flag;
   logic                   w_drop_flag_next;

   assign w_hit = sel_onehot(bus.in_sel);

   // Ready follows the targeted slot only; a drop can always be taken
   always_comb begin
      w_in_ready = 1'b1;
      case (bus.in_sel)
         SEL_CH0: w_in_ready = !w_full[0] | bus.out_ready[0];
         SEL_CH1: w_in_ready = !w_full[1] | bus.out_ready[1];
         SEL_CH2: w_in_ready = !w_full[2] | bus.out_ready[2];
         default: w_in_ready = 1'b1;
      endcase
   end

   assign w_accept = bus.in_valid & w_in_ready;
   assign w_drop   = w_accept & (bus.in_sel == SEL_INV);

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_slot
         assign w_load[gi]  = w_accept & w_hit[gi];
         assign w_drain[gi] = w_full[gi] & bus.out_ready[gi];

         vec_out_slot #(
            .N (N),
            .M (M)
         ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .i_load  (w_load[gi]),
            .i_drain (w_drain[gi]),
            .i_data  (bus.in_data),
            .o_full  (w_full[gi]),
            .o_data  (w_slot_data[gi])
         );
      end
   endgenerate

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_full;
   assign bus.out_data0 = w_slot_data[0];
   assign bus.out_data1 = w_slot_data[1];
   assign bus.out_data2 = w_slot_data[2];

   // Drop bookkeeping: clear applies first, then a same-cycle drop counts
   always_comb begin
      w_drop_count_next = clr_err ? '0 : r_drop_count;
      w_drop_flag_next  = clr_err ? 1'b0 : r_drop_flag;
      if (w_drop) begin
         w_drop_flag_next = 1'b1;
         if (w_drop_count_next != CNT_MAX) begin
            w_drop_count_next = w_drop_count_next + 1'b1;
         end
      end
   end

   // Drop counter and sticky flag registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_drop_count <= '0;
         r_drop_flag  <= 1'b0;
      end else begin
         r_drop_count <= w_drop_count_next;
         r_drop_flag  <= w_drop_flag_next;
      end
   end

   assign drop_count = r_drop_count;
   assign drop_flag  = r_drop_flag;

endmodule

// File: tb/tb_vec_demux3_router.sv
// Directed self-checking bench for vec_demux3_router.
module tb_vec_demux3_router;
   import vec_pkg::*;

   localparam int N     = 16;
   localparam int M     = 16;
   localparam int CNT_W = 8;

   logic             clk;
   logic             rst;
   logic             clr_err;
   logic [CNT_W-1:0] drop_count;
   logic             drop_flag;

   int n_checks;
   int n_errors;

   vec_demux3_router_if #(.N(N), .M(M)) bus ();

   vec_demux3_router #(
      .N     (N),
      .M     (M),
      .CNT_W (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .clr_err    (clr_err),
      .drop_count (drop_count),
      .drop_flag  (drop_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t fill(input logic [15:0] v);
      vec_t r;
      for (int l = 0; l < M; l++) r[l] = v;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance one rising edge and settle
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp_cnt;
      n_checks      = 0;
      n_errors      = 0;
      rst           = 1'b1;
      clr_err       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_sel    = SEL_CH0;
      bus.in_data   = '0;
      bus.out_ready = 3'b111;
      step();
      step();
      chk("rst_out_valid", 256'(bus.out_valid), 256'(3'b000));
      chk("rst_data0", 256'(bus.out_data0), 256'(0));
      chk("rst_data1", 256'(bus.out_data1), 256'(0));
      chk("rst_data2", 256'(bus.out_data2), 256'(0));
      chk("rst_cnt", 256'(drop_count), 256'(0));
      chk("rst_flag", 256'(drop_flag), 256'(0));
      rst = 1'b0;
      step();

      // single route to ch1
      bus.in_valid = 1'b1;
      bus.in_sel   = SEL_CH1;
      bus.in_data  = fill(16'hA5A5);
      chk("route_ready", 256'(bus.in_ready), 256'(1));
      step();
      bus.in_valid = 1'b0;
      chk("route_valid", 256'(bus.out_valid), 256'(3'b010));
      chk("route_data1", 256'(bus.out_data1), 256'(fill(16'hA5A5)));
      step();
      chk("route_empty", 256'(bus.out_valid), 256'(3'b000));

      // backpressure on ch2
      bus.out_ready = 3'b011;
      bus.in_valid  = 1'b1;
      bus.in_sel    = SEL_CH2;
      bus.in_data   = fill(16'h0001);
      step();
      bus.in_data = fill(16'h0002);
      chk("bp_ready0", 256'(bus.in_ready), 256'(0));
      chk("bp_valid", 256'(bus.out_valid), 256'(3'b100));
      chk("bp_data_a", 256'(bus.out_data2), 256'(fill(16'h0001)));
      step();
      chk("bp_hold_ready", 256'(bus.in_ready), 256'(0));
      chk("bp_hold_data", 256'(bus.out_data2), 256'(fill(16'h0001)));
      bus.out_ready = 3'b111;
      chk("bp_ready1", 256'(bus.in_ready), 256'(1));
      step();
      bus.in_valid = 1'b0;
      chk("bp_valid2", 256'(bus.out_valid), 256'(3'b100));
      chk("bp_data_b", 256'(bus.out_data2), 256'(fill(16'h0002)));
      step();
      chk("bp_empty", 256'(bus.out_valid), 256'(3'b000));

      // full throughput on ch0
      for (int i = 0; i < 8; i++) begin
         bus.in_valid = 1'b1;
         bus.in_sel   = SEL_CH0;
         bus.in_data  = fill(16'h0010 + 16'(i));
         chk("tp_ready", 256'(bus.in_ready), 256'(1));
         step();
         chk("tp_valid", 256'(bus.out_valid), 256'(3'b001));
         chk("tp_data0", 256'(bus.out_data0), 256'(fill(16'h0010 + 16'(i))));
      end
      bus.in_valid = 1'b0;
      step();
      chk("tp_empty", 256'(bus.out_valid), 256'(3'b000));

      // drops with saturation
      bus.in_valid = 1'b1;
      bus.in_sel   = SEL_INV;
      bus.in_data  = fill(16'hDEAD);
      exp_cnt      = 0;
      for (int i = 0; i < 260; i++) begin
         step();
         if (exp_cnt < 255) exp_cnt++;
         chk("drop_cnt", 256'(drop_count), 256'(exp_cnt));
      end
      chk("drop_no_valid", 256'(bus.out_valid), 256'(3'b000));
      chk("drop_flag", 256'(drop_flag), 256'(1));
      chk("drop_cnt_sat", 256'(drop_count), 256'(255));
      clr_err = 1'b1;
      step();
      clr_err      = 1'b0;
      bus.in_valid = 1'b0;
      chk("clr_drop_cnt", 256'(drop_count), 256'(1));
      chk("clr_drop_flag", 256'(drop_flag), 256'(1));
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      chk("clr_cnt", 256'(drop_count), 256'(0));
      chk("clr_flag", 256'(drop_flag), 256'(0));

      // channel independence: ch0 stalled
      bus.out_ready = 3'b110;
      bus.in_valid  = 1'b1;
      bus.in_sel    = SEL_CH0;
      bus.in_data   = fill(16'h0033);
      step();
      bus.in_data = fill(16'h0044);
      chk("ind_ready0", 256'(bus.in_ready), 256'(0));
      step();
      chk("ind_hold_valid", 256'(bus.out_valid), 256'(3'b001));
      chk("ind_hold_data", 256'(bus.out_data0), 256'(fill(16'h0033)));
      bus.in_sel  = SEL_CH1;
      bus.in_data = fill(16'h0055);
      chk("ind_ready1", 256'(bus.in_ready), 256'(1));
      step();
      bus.in_valid = 1'b0;
      chk("ind_valid", 256'(bus.out_valid), 256'(3'b011));
      chk("ind_data0", 256'(bus.out_data0), 256'(fill(16'h0033)));
      chk("ind_data1", 256'(bus.out_data1), 256'(fill(16'h0055)));
      step();
      chk("ind_drain1", 256'(bus.out_valid), 256'(3'b001));

      // one drop, then async reset with ch0 still full
      bus.in_valid = 1'b1;
      bus.in_sel   = SEL_INV;
      step();
      bus.in_valid = 1'b0;
      chk("pre_rst_cnt", 256'(drop_count), 256'(1));
      chk("pre_rst_valid", 256'(bus.out_valid), 256'(3'b001));
      #1;
      rst = 1'b1;
      #1;
      chk("arst_valid", 256'(bus.out_valid), 256'(3'b000));
      chk("arst_data0", 256'(bus.out_data0), 256'(0));
      chk("arst_data1", 256'(bus.out_data1), 256'(0));
      chk("arst_cnt", 256'(drop_count), 256'(0));
      chk("arst_flag", 256'(drop_flag), 256'(0));
      step();
      rst = 1'b0;
      step();
      chk("post_rst_valid", 256'(bus.out_valid), 256'(3'b000));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/vec_demux3_router.md
Name: vec_demux3_router

Overview:
Routes one M-lane x N-bit vector from a single valid/ready source to one of three vector destinations (channels 0/1/2), selected per transfer by a 2-bit code. It is the distribution counterpart of the 3:1 vector select in the vector datapath, used to steer a result vector to writeback, store or forwarding paths. Each channel has a one-entry registered output slot. Invalid select codes are consumed, dropped and counted.

Parameters:
N, 16, bits per lane
M, 16, number of lanes
CNT_W, 8, width of the saturating drop counter

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  source vector valid
in_ready  out  1  router accepts the source vector this cycle
in_sel  in  2  destination code: 00=ch0, 01=ch1, 10=ch2, 11=invalid
in_data  in  [M-1:0][N-1:0]  source vector
out_valid  out  3  per-channel slot full, bit k = channel k
out_ready  in  3  per-channel sink ready, bit k = channel k
out_data0  out  [M-1:0][N-1:0]  channel 0 vector
out_data1  out  [M-1:0][N-1:0]  channel 1 vector
out_data2  out  [M-1:0][N-1:0]  channel 2 vector
clr_err  in  1  synchronous clear of drop_count and drop_flag
drop_count  out  CNT_W  saturating count of dropped (sel=11) transfers
drop_flag  out  1  sticky, set on any drop

Behaviour:
- Reset (async, rst=1): all slots empty (out_valid=000), out_data0..2=0, drop_count=0, drop_flag=0. Reset mid-transfer discards slot contents. Nothing is accepted while rst=1.
- Transfer rules: source transfer when in_valid & in_ready. Channel k transfer when out_valid[k] & out_ready[k].
- in_ready is combinational:
  - sel in {00,01,10} targeting k: in_ready = !out_valid[k] | out_ready[k].
  - sel=11: in_ready = 1.
  - in_ready is independent of in_valid.
- Accept into channel k:
  - Next cycle out_valid[k]=1 and out_dataK=in_data.
  - Latency is 1 cycle from acceptance to out_valid.
- Simultaneous drain and load on the same channel: slot stays full and takes the new vector, so throughput is 1 vector/cycle per channel.
- Drain with no load: out_valid[k] deasserts next cycle. out_dataK holds its last value and is don't-care for checkers.
- Holding stable: while out_valid[k]=1 and out_ready[k]=0, out_dataK and out_valid[k] hold.
- Channel independence: other channels drain independently. Ordering is guaranteed only within a channel.
- Drop (sel=11 accepted): no slot is written. drop_flag is set. drop_count increments and saturates at 2^CNT_W-1 with no wrap.
- clr_err=1: drop_count=0 and drop_flag=0 next cycle. If a drop occurs in the same cycle, clear applies first and then the drop, giving drop_count=1 and drop_flag=1.
- No state machine beyond the per-slot full bit. Each slot has two states:
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain without load.
  - FULL -> FULL on load with or without drain.

Decomposition:
- Package vec_pkg:
  - localparams SEL_CH0=2'b00, SEL_CH1=2'b01, SEL_CH2=2'b10, SEL_INV=2'b11.
  - Typedef vec_t = logic [M-1:0][N-1:0], with package defaults N=M=16.
- Sub-module vec_out_slot: a one-entry registered slot with load/drain/full/data, parameterised on N and M, instantiated three times.
- Top-level logic: select decode, in_ready mux, and the drop counter/flag.

Test Plan:
- Reset then idle: rst pulse mid-simulation with a full slot -> out_valid=000, out_data*=0, drop_count=0 immediately (async), with no clock edge needed.
- Single route: in_sel=01, in_data lanes=16'hA5A5, out_ready=111 -> out_valid=010 one cycle later with out_data1=all 16'hA5A5; out_valid=000 the cycle after.
- Backpressure: out_ready[2]=0, two back-to-back sel=10 vectors 16'h0001 and 16'h0002 -> first held in ch2, in_ready=0 for the second. Raise out_ready[2] -> 16'h0001 drains, 16'h0002 loads the same cycle, 16'h0002 is seen next.
- Full throughput: stream 8 vectors to ch0 with out_ready=111 -> in_ready constantly 1, out_valid[0] high 8 consecutive cycles with data in order.
- Drop/saturation: 260 sel=11 transfers with CNT_W=8 -> no out_valid, drop_count=255, drop_flag=1. Then clr_err together with one sel=11 -> drop_count=1, drop_flag=1.
- Channel independence: ch0 stalled (out_ready[0]=0, slot full), sel=00 then sel=01 presented -> sel=00 waits with in_ready=0. After switching sel to 01, it is accepted and out_valid[1] rises while ch0 stays held.
